cmp_arbiter: RTL and testbench

Shares one 32-bit compare datapath between up to four requesters, such as the branch-resolve unit and the set-less-than path. Requests use a valid/ready handshake. A round-robin arbiter grants one request at a time. The block latches the operands, evaluates the compare, and holds the 1-bit result until the owner consumes it. It sits between the decode/execute stage requesters and the compare datapath.

---
 rtl/cmp_arbiter.sv | 155 +++++++++++++++
 tb/tb_cmp_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin arbiter sharing one compare datapath among
// NREQ (2..4) requesters. Accept -> EVAL -> RESP; the 1-bit result is held
// until resp_ready.
// Optional feature macro: CMP_ARB_SIGNED_EN adds req_signed, which selects
// two's-complement ordering for the relational opcodes (001..100).
module cmp_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_op,
`ifdef CMP_ARB_SIGNED_EN
  input  logic [NREQ-1:0]       req_signed,
`endif
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [1:0]            resp_id,
  output logic                  resp_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [1:0]       last_grant;
  logic [1:0]       grant_idx;
  logic [1:0]       cand;
  logic             grant_found;
  logic [NREQ-1:0]  valid_rot;
  logic             accept;

  logic [WIDTH-1:0] a_sel, b_sel;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] lat_a, lat_b;
  logic [2:0]       lat_op;
  logic [1:0]       lat_id;
  logic             cmp_out;
  logic             is_eq, is_lt;
`ifdef CMP_ARB_SIGNED_EN
  logic             signed_sel;
  logic             lat_signed;
`endif

  // Round-robin search starting just after the last granted requester
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    valid_rot   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand      = 2'((32'(last_grant) + k) % NREQ);
      valid_rot = req_valid >> cand;
      if (!grant_found && valid_rot[0]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign accept = (state == IDLE) && grant_found;

  // Operand selection for the current winner
  always_comb begin
    a_sel  = WIDTH'(req_a >> (int'(grant_idx) * WIDTH));
    b_sel  = WIDTH'(req_b >> (int'(grant_idx) * WIDTH));
    op_sel = 3'(req_op >> (int'(grant_idx) * 3));
`ifdef CMP_ARB_SIGNED_EN
    signed_sel = 1'(req_signed >> grant_idx);
`endif
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (grant_found) state_next = EVAL;
      EVAL:    state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: ready is a one-hot grant only while idle
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (grant_idx == 2'(i));
    end
    resp_valid = (state == RESP);
  end

  // Compare of latched operands; signed ordering only affects relational ops
  always_comb begin
    is_eq = (lat_a == lat_b);
`ifdef CMP_ARB_SIGNED_EN
    is_lt = lat_signed ? ($signed(lat_a) < $signed(lat_b)) : (lat_a < lat_b);
`else
    is_lt = (lat_a < lat_b);
`endif
    unique case (lat_op)
      3'b000:  cmp_out = is_eq;
      3'b001:  cmp_out = !is_lt;
      3'b010:  cmp_out = is_lt || is_eq;
      3'b011:  cmp_out = !(is_lt || is_eq);
      3'b100:  cmp_out = is_lt;
      3'b101:  cmp_out = !is_eq;
      default: cmp_out = 1'b0;
    endcase
  end

  // Request latch on acceptance, result capture in EVAL
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_a       <= '0;
      lat_b       <= '0;
      lat_op      <= '0;
      lat_id      <= '0;
      last_grant  <= 2'(NREQ - 1);
      resp_result <= 1'b0;
`ifdef CMP_ARB_SIGNED_EN
      lat_signed  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        lat_a      <= a_sel;
        lat_b      <= b_sel;
        lat_op     <= op_sel;
        lat_id     <= grant_idx;
        last_grant <= grant_idx;
`ifdef CMP_ARB_SIGNED_EN
        lat_signed <= signed_sel;
`endif
      end
      if (state == EVAL) resp_result <= cmp_out;
    end
  end

  assign resp_id = lat_id;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter (NREQ=3): directed scenarios plus
// randomized traffic against a round-robin / compare reference model;
// responses are checked from a scoreboard queue by a separate monitor.
module tb_cmp_arbiter;

  localparam int N = 3;
  localparam int W = 32;

  logic             clock;
  logic             reset_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N*3-1:0]   req_op;
`ifdef CMP_ARB_SIGNED_EN
  logic [N-1:0]     req_signed;
`endif
  logic             resp_valid;
  logic             resp_ready;
  logic [1:0]       resp_id;
  logic             resp_result;

  cmp_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
`ifdef CMP_ARB_SIGNED_EN
    .req_signed  (req_signed),
`endif
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int unsigned id;
    bit          res;
  } exp_t;

  exp_t exp_q[$];
  int   dut_grants[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model state: phase 0 idle, 1 evaluating, 2 holding response
  int   m_phase;
  int   m_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
  endtask

  function automatic bit ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input bit sgn);
    longint va, vb;
    if (sgn) begin
      va = $signed(a);
      vb = $signed(b);
    end else begin
      va = a;
      vb = b;
    end
    case (op)
      3'd0:    return va == vb;
      3'd1:    return va >= vb;
      3'd2:    return va <= vb;
      3'd3:    return va > vb;
      3'd4:    return va < vb;
      3'd5:    return va != vb;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic bit get_sgn(input int w);
`ifdef CMP_ARB_SIGNED_EN
    return req_signed[w];
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_op[i*3 +: 3] = op;
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_last  = N - 1;
    exp_q.delete();
  endtask

  // Checks handshake outputs against the model and advances it one cycle
  task automatic check_and_model();
    logic [N-1:0] exp_ready;
    int w;
    exp_ready = '0;
    w = -1;
    if (m_phase == 0) begin
      w = rr_pick(req_valid, m_last);
      if (w >= 0) exp_ready[w] = 1'b1;
    end
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("resp_valid", 64'(resp_valid), 64'(m_phase == 2));
    for (int i = 0; i < N; i++) if (req_ready[i]) dut_grants.push_back(i);
    case (m_phase)
      0: if (w >= 0) begin
           exp_q.push_back('{id: w,
                             res: ref_cmp(req_a[w*W +: W], req_b[w*W +: W],
                                          req_op[w*3 +: 3], get_sgn(w))});
           m_last  = w;
           m_phase = 1;
         end
      1: m_phase = 2;
      default: if (resp_ready) m_phase = 0;
    endcase
  endtask

  // One clock: inputs already driven; check at negedge, return at posedge+1
  task automatic step();
    @(negedge clock);
    check_and_model();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic drain();
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (4) step();
  endtask

  // Scoreboard monitor: every consumed response must match the queue head
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_id", 64'(resp_id), 64'(e.id));
        chk("resp_result", 64'(resp_result), 64'(e.res));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    logic [1:0] held_id;
    logic       held_res;
    logic [7:0] sweep_exp;
    int         ng;

    reset_n    = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b0;
`ifdef CMP_ARB_SIGNED_EN
    req_signed = '0;
`endif
    model_reset();
    #1;
    chk("rst_async_valid", 64'(resp_valid), 64'd0);
    do_reset();

    // Reset state with no requests
    repeat (4) begin
      step();
      chk("rst_result", 64'(resp_result), 64'd0);
      chk("rst_id", 64'(resp_id), 64'd0);
    end

    // Single request from requester 0
    set_req(0, 32'd5, 32'd5, 3'b000);
    req_valid  = 3'b001;
    resp_ready = 1'b1;
    step();
    chk("single_grant", 64'(dut_grants.size() > 0 ? dut_grants[$] : -1), 64'd0);
    req_valid = '0;
    step();
    chk("single_valid", 64'(resp_valid), 64'd1);
    chk("single_result", 64'(resp_result), 64'd1);
    chk("single_id", 64'(resp_id), 64'd0);
    step();
    ng = dut_grants.size();
    req_valid = 3'b001;
    step();
    chk("single_idle_next", 64'(dut_grants.size()), 64'(ng + 1));
    drain();

    // Round-robin between requesters 0 and 1 from reset
    do_reset();
    dut_grants.delete();
    set_req(0, 32'd7, 32'd3, 3'b011);
    set_req(1, 32'd7, 32'd3, 3'b011);
    req_valid  = 3'b011;
    resp_ready = 1'b1;
    repeat (12) step();
    drain();
    chk("rr_count", 64'(dut_grants.size()), 64'd4);
    for (int i = 0; i < 4 && i < dut_grants.size(); i++)
      chk($sformatf("rr_grant%0d", i), 64'(dut_grants[i]), 64'(i % 2));

    // Backpressure with a competing request pending
    set_req(0, 32'd9, 32'd4, 3'b011);
    set_req(1, 32'd1, 32'd2, 3'b100);
    req_valid  = 3'b001;
    resp_ready = 1'b0;
    step();
    req_valid = 3'b010;
    step();
    held_id  = resp_id;
    held_res = resp_result;
    chk("bp_valid", 64'(resp_valid), 64'd1);
    repeat (10) begin
      set_req(0, $urandom, $urandom, 3'($urandom));
      step();
      chk("bp_id_stable", 64'(resp_id), 64'(held_id));
      chk("bp_result_stable", 64'(resp_result), 64'(held_res));
    end
    resp_ready = 1'b1;
    step();
    ng = dut_grants.size();
    step();
    chk("bp_req1_accepted", 64'(dut_grants.size() == ng + 1 ? dut_grants[$] : -1), 64'd1);
    drain();

    // Opcode sweep on a = 0xFFFFFFFF, b = 1
    sweep_exp = 8'b0010_1010;
    for (int op = 0; op < 8; op++) begin
      set_req(0, 32'hFFFF_FFFF, 32'd1, 3'(op));
      req_valid  = 3'b001;
      resp_ready = 1'b1;
      step();
      req_valid = '0;
      step();
      chk($sformatf("sweep_op%0d", op), 64'(resp_result), 64'(sweep_exp[op]));
      step();
    end
`ifdef CMP_ARB_SIGNED_EN
    req_signed = 3'b001;
    set_req(0, 32'hFFFF_FFFF, 32'd1, 3'b100);
    req_valid = 3'b001;
    step();
    req_valid = '0;
    step();
    chk("sweep_signed_lt", 64'(resp_result), 64'd1);
    step();
    req_signed = '0;
`endif
    drain();

    // Reset while a response is pending
    set_req(2, 32'd3, 32'd3, 3'b101);
    req_valid  = 3'b100;
    resp_ready = 1'b0;
    step();
    req_valid = '0;
    step();
    chk("rstmid_valid_before", 64'(resp_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rstmid_valid_async", 64'(resp_valid), 64'd0);
    chk("rstmid_result", 64'(resp_result), 64'd0);
    chk("rstmid_id", 64'(resp_id), 64'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    req_valid  = 3'b111;
    resp_ready = 1'b1;
    step();
    chk("rstmid_prio0", 64'(dut_grants.size() > 0 ? dut_grants[$] : -1), 64'd0);
    drain();

    // Randomized traffic
    repeat (400) begin
      for (int i = 0; i < N; i++) begin
        logic [31:0] a;
        a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
        set_req(i, a, ($urandom_range(0, 3) == 0) ? a : $urandom, 3'($urandom_range(0, 7)));
      end
      req_valid  = N'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
`ifdef CMP_ARB_SIGNED_EN
      req_signed = N'($urandom);
`endif
      step();
    end
    drain();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
